// File: rtl/router_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | router_pkg : shared types and constants for the router control   |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
package router_pkg;

  localparam int         NUM_PORTS    = 3;
  localparam int         DATA_W       = 8;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_EMPTY  = 3'd1,
    LOAD_FIRST  = 3'd2,
    LOAD_DATA   = 3'd3,
    LOAD_PARITY = 3'd4,
    DROP        = 3'd5
  } state_t;

  // One-hot port select; the invalid address maps to no port at all.
  function automatic logic [NUM_PORTS-1:0] port_sel(input logic [1:0] addr);
    port_sel = NUM_PORTS'(1) << addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_timeout.sv
`default_nettype none
// +------------------------------------------------------------------+
// | router_timeout : per-FIFO idle watchdog, one-cycle soft reset    |
// | Revision       : 1.0                                             |
// +------------------------------------------------------------------+
module router_timeout #(
  parameter int TIMEOUT = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic i_fifo_empty,
  input  logic i_read_en,
  output logic o_soft_rst
);

  localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_soft_rst;

  // Counts stalled cycles; the terminal cycle raises the pulse and restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_soft_rst <= 1'b0;
    end else if (i_fifo_empty || i_read_en) begin
      r_cnt      <= '0;
      r_soft_rst <= 1'b0;
    end else if (r_cnt == c_last) begin
      r_cnt      <= '0;
      r_soft_rst <= 1'b1;
    end else begin
      r_cnt      <= r_cnt + 1'b1;
      r_soft_rst <= 1'b0;
    end
  end

  assign o_soft_rst = r_soft_rst;

endmodule
`default_nettype wire

// File: rtl/router_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | router_ctrl : packet router FSM, FIFO write steering, watchdogs  |
// | Option      : ROUTER_PARITY_CHECK_EN enables parity checking     |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module router_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30,
  parameter int LEN_W   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_valid,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] read_en,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] we,
  output logic [NUM_PORTS-1:0] valid_out,
  output logic [NUM_PORTS-1:0] soft_rst,
  output logic [DATA_W-1:0]    data_out,
  output logic                 lfd_state,
  output logic                 parity_err
);

  state_t                r_state;
  state_t                w_next;
  logic [DATA_W-1:0]     r_hdr;
  logic [1:0]            r_addr;
  logic [LEN_W-1:0]      r_cnt;

  logic                  w_accept;
  logic [1:0]            w_in_addr;
  logic [NUM_PORTS-1:0]  w_in_sel;
  logic [NUM_PORTS-1:0]  w_sel;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_srst;
  logic                  w_hdr_ok;
  logic [LEN_W-1:0]      w_len;

  assign w_accept  = pkt_valid & ~busy;
  assign w_in_addr = data_in[1:0];
  assign w_in_sel  = port_sel(w_in_addr);
  assign w_sel     = port_sel(r_addr);
  assign w_full    = |(fifo_full & w_sel);
  assign w_empty   = |(fifo_empty & w_sel);
  assign w_srst    = |(soft_rst & w_sel);
  assign w_hdr_ok  = w_accept && (w_in_addr != ADDR_INVALID);
  assign w_len     = r_hdr[DATA_W-1 -: LEN_W];
  assign valid_out = ~fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:        if (w_hdr_ok) w_next = (|(fifo_empty & w_in_sel)) ? LOAD_FIRST : WAIT_EMPTY;
      WAIT_EMPTY:  if (w_empty) w_next = LOAD_FIRST;
      LOAD_FIRST: begin
        if (w_srst)       w_next = DROP;
        else if (!w_full) w_next = (w_len == '0) ? LOAD_PARITY : LOAD_DATA;
      end
      LOAD_DATA: begin
        if (w_srst)                                  w_next = DROP;
        else if (w_accept && (r_cnt == LEN_W'(1)))   w_next = LOAD_PARITY;
      end
      // A parity byte accepted in the soft-reset cycle still completes the packet.
      LOAD_PARITY: begin
        if (w_accept)    w_next = IDLE;
        else if (w_srst) w_next = DROP;
      end
      DROP:        if (w_accept && (r_cnt == '0)) w_next = IDLE;
      default:     w_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    we        = '0;
    data_out  = '0;
    lfd_state = 1'b0;
    case (r_state)
      WAIT_EMPTY: busy = 1'b1;
      LOAD_FIRST: begin
        busy      = 1'b1;
        lfd_state = 1'b1;
        data_out  = r_hdr;
        we        = w_sel & {NUM_PORTS{~w_full & ~w_srst}};
      end
      LOAD_DATA, LOAD_PARITY: begin
        busy     = w_full;
        data_out = data_in;
        we       = w_sel & {NUM_PORTS{pkt_valid & ~w_full & ~w_srst}};
      end
      default: ;
    endcase
  end

  // Counter holds bytes still owed before the parity byte, also while dropping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hdr  <= '0;
      r_addr <= '0;
      r_cnt  <= '0;
    end else begin
      if ((r_state == IDLE) && w_hdr_ok) begin
        r_hdr  <= data_in;
        r_addr <= w_in_addr;
      end
      if (r_state == LOAD_FIRST) begin
        r_cnt <= w_len;
      end else if (((r_state == LOAD_DATA) || (r_state == LOAD_PARITY) || (r_state == DROP))
                   && w_accept && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

`ifdef ROUTER_PARITY_CHECK_EN
  logic [DATA_W-1:0] r_xor;
  logic              r_perr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xor  <= '0;
      r_perr <= 1'b0;
    end else if ((r_state == IDLE) && w_hdr_ok) begin
      r_xor  <= data_in;
      r_perr <= 1'b0;
    end else if ((r_state == LOAD_DATA) && w_accept) begin
      r_xor  <= r_xor ^ data_in;
    end else if ((r_state == LOAD_PARITY) && w_accept) begin
      r_perr <= (r_xor != data_in);
    end
  end

  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_timeout
    router_timeout #(
      .TIMEOUT (TIMEOUT)
    ) u_timeout (
      .clk          (clk),
      .rst          (rst),
      .i_fifo_empty (fifo_empty[gi]),
      .i_read_en    (read_en[gi]),
      .o_soft_rst   (soft_rst[gi])
    );
  end

endmodule
`default_nettype wire

// File: doc/router_ctrl.md
ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 30, meaning consecutive unread cycles before a FIFO soft reset.
REQ-002 SHALL have parameter LEN_W, default 6, meaning header payload-length field width.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port pkt_valid  in  1  source byte valid.
REQ-006 SHALL have port data_in  in  8  source byte; header = {len[7:2], addr[1:0]}.
REQ-007 SHALL have ports fifo_full, fifo_empty, read_en  in  3 each  per-FIFO status and downstream read strobes.
REQ-008 SHALL have port busy  out  1  source must hold its byte while high.
REQ-009 SHALL have ports we, valid_out, soft_rst  out  3 each  FIFO write enables, ~fifo_empty, per-FIFO soft reset.
REQ-010 SHALL have ports data_out  out  8, lfd_state  out  1, parity_err  out  1.

Function
REQ-011 A byte SHALL be accepted only on a cycle with pkt_valid=1 and busy=0.
REQ-012 FSM states SHALL be IDLE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, LOAD_PARITY, DROP.
REQ-013 IDLE: busy=0; accepted byte with addr!=3 latched into hdr/addr registers, next state LOAD_FIRST if fifo_empty[addr] else WAIT_EMPTY; addr=3 byte discarded, stay IDLE.
REQ-014 WAIT_EMPTY: busy=1, we=0; to LOAD_FIRST on the first cycle fifo_empty[addr]=1.
REQ-015 LOAD_FIRST: busy=1, we[addr]=1, lfd_state=1, data_out=hdr, remaining counter loaded with len; next LOAD_DATA, or LOAD_PARITY if len=0.
REQ-016 LOAD_DATA: busy=fifo_full[addr]; each accepted byte drives we[addr]=1 and data_out=data_in combinationally in the same cycle and decrements the counter; counter reaching 0 moves to LOAD_PARITY.
REQ-017 LOAD_PARITY: same handshake as LOAD_DATA; accepted parity byte is written to FIFO, next IDLE.
REQ-018 Header-to-first-payload latency SHALL be 2 cycles minimum (header cycle N, LOAD_FIRST N+1, payload accepted N+2).
REQ-019 we SHALL be one-hot or zero; we[addr] never asserted while fifo_full[addr]=1.
REQ-020 Per FIFO i, timer SHALL count cycles with fifo_empty[i]=0 and read_en[i]=0, clear on read_en[i]=1 or fifo_empty[i]=1.
REQ-021 After TIMEOUT consecutive counted cycles soft_rst[i] SHALL pulse high for exactly one cycle (registered) and the timer SHALL clear.
REQ-022 soft_rst[addr] in LOAD_FIRST, LOAD_DATA or LOAD_PARITY SHALL move FSM to DROP; in WAIT_EMPTY it SHALL have no FSM effect.
REQ-023 DROP: busy=0, we=0; accepted bytes consume the counter then the parity byte, then IDLE.
REQ-024 Simultaneous soft_rst on a non-active FIFO SHALL not affect the FSM.

Reset
REQ-025 rst SHALL asynchronously force IDLE, counter/hdr/addr/timers=0, busy=0, we=0, soft_rst=0, lfd_state=0, parity_err=0, data_out=0; mid-packet rst abandons the packet with no further writes.

Configuration
REQ-026 With ROUTER_PARITY_CHECK_EN defined, a running XOR over header and payload SHALL be compared with the parity byte; parity_err registered high the cycle after a mismatching parity byte is accepted, held until next header accepted.
REQ-027 Without ROUTER_PARITY_CHECK_EN, no XOR register SHALL exist and parity_err SHALL be constant 0; parity byte still written.

Structure
REQ-028 Package router_pkg SHALL hold the state enum, NUM_PORTS=3, DATA_W=8, ADDR_INVALID=2'b11.
REQ-029 Timer SHALL be sub-module router_timeout, instantiated once per FIFO.

Verification
REQ-030 Header 8'h0D (len 3, addr 1), FIFO1 empty, 3 payload + parity streamed -> we[1] 5 cycles, lfd_state=1 only with header, busy high only in LOAD_FIRST.
REQ-031 Header addr 2 while fifo_empty[2]=0 -> busy=1 in WAIT_EMPTY; fifo_empty[2]->1 -> header written next cycle.
REQ-032 fifo_full[0] asserted for 4 cycles mid-payload -> busy=1, we=0 for those cycles, no byte lost or duplicated.
REQ-033 FIFO2 non-empty, read_en[2]=0 for 30 cycles -> soft_rst[2] high exactly 1 cycle after cycle 30; read_en[2] pulse at cycle 29 -> no soft_rst.
REQ-034 soft_rst on active FIFO during LOAD_DATA -> DROP, remaining bytes accepted with we=0, FSM returns IDLE after parity byte.
REQ-035 ROUTER_PARITY_CHECK_EN: header 8'h04, payload 8'hA5, parity 8'h00 -> parity_err=1; parity 8'hA1 -> parity_err=0.
